// File: rtl/alu_div_pkg.sv
// Shared definitions for the alu_divn sequential divider: FSM state codes,
// count-width helper and the widened two's-complement magnitude function.
package alu_div_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 32;
  // Wide enough that any legal WIDTH leaves at least one spare bit above WIDTH.
  localparam int ABS_W         = MAX_WIDTH + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Operand must already be sign- or zero-extended to ABS_W bits.
  function automatic logic [ABS_W-1:0] abs_ext(input logic [ABS_W-1:0] v);
    return v[ABS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/alu_divn_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module alu_divn_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  assign shifted = {rem_in, dividend_bit};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  // The kept value is always below the divisor, so it fits in WIDTH bits.
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/alu_divn.sv
// Sequential signed/unsigned divider, one restoring step per clock, WIDTH-cycle latency.
// Define ALU_DIVN_FASTPATH_EN to finish trivial cases (b==0, MIN/-1, |b|==1, |a|<|b|) at accept.
module alu_divn
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               CNT_W   = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dq;
  logic             sign_q;
  logic             sign_r;
  logic             op_signed;
  logic             op_dz;
  logic             op_ovf;

  logic [ABS_W-1:0] a_abs;
  logic [ABS_W-1:0] b_abs;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             in_sign_q;
  logic             in_sign_r;
  logic             in_dz;
  logic             in_ovf;
  logic             unused_abs;

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  assign a_abs = abs_ext({{(ABS_W-WIDTH){is_signed & a[WIDTH-1]}}, a});
  assign b_abs = abs_ext({{(ABS_W-WIDTH){is_signed & b[WIDTH-1]}}, b});
  // Magnitudes never exceed 2^WIDTH-1 (signed MIN gives 2^(WIDTH-1)).
  assign a_mag      = a_abs[WIDTH-1:0];
  assign b_mag      = b_abs[WIDTH-1:0];
  assign unused_abs = ^{a_abs[ABS_W-1:WIDTH], b_abs[ABS_W-1:WIDTH]};

  assign in_sign_q = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign in_sign_r = is_signed & a[WIDTH-1];
  assign in_dz     = (b == '0);
  assign in_ovf    = is_signed & (a == MIN_NEG) & (b == '1);

  alu_divn_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem),
    .divisor      (dvsr),
    .dividend_bit (dq[WIDTH-1]),
    .rem_out      (rem_nxt),
    .q_bit        (q_bit)
  );

  assign q_mag = {dq[WIDTH-2:0], q_bit};

  // MIN/-1 needs no override: the magnitude 2^(WIDTH-1) already reads back as MIN.
  always_comb begin
    res_q = sign_q ? -q_mag : q_mag;
    res_r = sign_r ? -rem_nxt : rem_nxt;
    if (op_dz) begin
      res_q = !op_signed ? '1 : (sign_r ? MIN_NEG : MAX_POS);
    end
  end

`ifdef ALU_DIVN_FASTPATH_EN
  logic             fast;
  logic [WIDTH-1:0] fast_q;
  logic [WIDTH-1:0] fast_r;

  always_comb begin
    fast   = in_dz | in_ovf | (b_mag == WIDTH'(1)) | (a_mag < b_mag);
    fast_q = '0;
    fast_r = a;
    if (in_dz) begin
      fast_q = !is_signed ? '1 : (in_sign_r ? MIN_NEG : MAX_POS);
    end else if (in_ovf) begin
      fast_q = MIN_NEG;
      fast_r = '0;
    end else if (b_mag == WIDTH'(1)) begin
      fast_q = in_sign_q ? -a_mag : a_mag;
      fast_r = '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dvsr        <= '0;
      dq          <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      op_signed   <= 1'b0;
      op_dz       <= 1'b0;
      op_ovf      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            rem       <= '0;
            dq        <= a_mag;
            dvsr      <= b_mag;
            sign_q    <= in_sign_q;
            sign_r    <= in_sign_r;
            op_signed <= is_signed;
            op_dz     <= in_dz;
            op_ovf    <= in_ovf;
            state     <= CALC;
`ifdef ALU_DIVN_FASTPATH_EN
            if (fast) begin
              quotient    <= fast_q;
              remainder   <= fast_r;
              div_by_zero <= in_dz;
              overflow    <= in_ovf;
              state       <= DONE;
            end
`endif
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dq  <= {dq[WIDTH-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= op_dz;
            overflow    <= op_ovf;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
